// File: rtl/ram_pkg.sv
// Shared widths and the wrapping pointer increment for the RAM FIFO controller.
package ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  // Next pointer value, wrapping modulo 2**aw (aw must be below 32).
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned aw);
    return (p + 32'd1) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer with synchronous clear and count enable.
module fifo_ptr
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  // Advance by one on enable; the increment helper handles the wrap.
  always_ff @(posedge clk) begin
    if (rst)       r_ptr <= '0;
    else if (i_en) r_ptr <= ADDR_W'(ptr_inc(32'(r_ptr), ADDR_W));
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word fall-through FIFO controller driving an external dual-port RAM
// whose read port registers its address and returns data combinationally.
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [DATA_W-1:0] ram_din1,
  output logic              ram_we1,
  output logic [ADDR_W-1:0] ram_addr2,
  output logic              ram_we2,
  input  logic [DATA_W-1:0] ram_dout2
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   r_count, r_unfetched;
  logic [ADDR_W:0]   w_count_nxt, w_unfetched_nxt;
  logic [ADDR_W-1:0] r_hptr, w_wptr, w_rptr;
  logic              r_rd_valid, r_full, r_empty;
  logic              w_wr, w_rd, w_fetch;

  // Write accepted only when not full; reset blocks the RAM write strobe.
  assign w_wr    = wr_valid && !r_full && !rst;
  assign w_rd    = r_rd_valid && rd_ready;
  // Fetch the next stored word when the output slot is empty or being drained.
  assign w_fetch = (r_unfetched != '0) && (!r_rd_valid || rd_ready);

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_wr),
    .o_ptr(w_wptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_fetch),
    .o_ptr(w_rptr)
  );

  // Occupancy and not-yet-presented word counts for the next cycle.
  always_comb begin
    w_count_nxt     = r_count;
    w_unfetched_nxt = r_unfetched;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + ONE_C;
      2'b01:   w_count_nxt = r_count - ONE_C;
      default: w_count_nxt = r_count;
    endcase
    case ({w_wr, w_fetch})
      2'b10:   w_unfetched_nxt = r_unfetched + ONE_C;
      2'b01:   w_unfetched_nxt = r_unfetched - ONE_C;
      default: w_unfetched_nxt = r_unfetched;
    endcase
  end

  // Presented-word pointer, output valid and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hptr      <= '0;
      r_unfetched <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end else begin
      if (w_fetch) begin
        r_hptr     <= w_rptr;
        r_rd_valid <= 1'b1;
      end else if (w_rd) begin
        r_rd_valid <= 1'b0;
      end
      r_unfetched <= w_unfetched_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == DEPTH_C);
      r_empty     <= (w_count_nxt == '0);
    end
  end

  // Hold the RAM read address on the presented word so rd_data stays put.
  assign ram_addr2 = w_fetch ? w_rptr : r_hptr;
  assign ram_we2   = 1'b0;
  assign ram_we1   = w_wr;
  assign ram_addr1 = w_wptr;
  assign ram_din1  = wr_data;
  assign rd_data   = ram_dout2;
  assign rd_valid  = r_rd_valid;
  assign wr_ready  = !r_full;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a queue-based FIFO model.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 1024;

  logic        clk, rst, wr_valid, rd_ready;
  logic [7:0]  wr_data, rd_data, ram_din1, ram_dout2;
  logic        wr_ready, rd_valid, full, empty, ram_we1, ram_we2;
  logic [10:0] count;
  logic [9:0]  ram_addr1, ram_addr2, r_a2;
  logic [7:0]  mem [0:DEPTH-1];

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .count(count),
    .full(full), .empty(empty), .ram_addr1(ram_addr1), .ram_din1(ram_din1),
    .ram_we1(ram_we1), .ram_addr2(ram_addr2), .ram_we2(ram_we2), .ram_dout2(ram_dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM: sync write, registered read address, combinational data.
  always @(posedge clk) begin
    if (ram_we1) mem[ram_addr1] <= ram_din1;
    r_a2 <= ram_addr2;
  end
  assign ram_dout2 = mem[r_a2];

  // Reference model: unread words in order, each stamped with its write edge.
  logic [7:0] q_data[$];
  int         q_stamp[$];
  int         cyc, n_chk, n_fail;
  logic       last_rd, last_wr;
  logic [7:0] last_rd_obs, last_rd_exp;

  // A word is on the output once it has sat in the FIFO across one more edge.
  function automatic logic exp_valid();
    return (q_data.size() > 0) && (q_stamp[0] < cyc);
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge.
  task automatic step(input logic r, input logic wv, input logic [7:0] wd, input logic rr);
    logic wr_ok, rd_ok;
    rst = r; wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    wr_ok = !r && wv && (q_data.size() < DEPTH);
    rd_ok = !r && rr && exp_valid();
    last_rd = rd_ok;
    last_wr = wr_ok;
    last_rd_obs = rd_data;
    last_rd_exp = (q_data.size() > 0) ? q_data[0] : 8'h00;
    @(posedge clk);
    cyc++;
    if (r) begin
      q_data.delete();
      q_stamp.delete();
    end else begin
      if (rd_ok) begin
        void'(q_data.pop_front());
        void'(q_stamp.pop_front());
      end
      if (wr_ok) begin
        q_data.push_back(wd);
        q_stamp.push_back(cyc);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    n_chk++; if (count !== 11'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    n_chk++; if (ram_we2 !== 1'b0) begin n_fail++; $display("FAIL reset_we2 got %b exp 0", ram_we2); end
    step(0, 0, 8'h00, 0);
  endtask

  task automatic test_single();
    step(0, 1, 8'hA5, 1);
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b exp 0", rd_valid); end
    n_chk++; if (count !== 11'd1) begin n_fail++; $display("FAIL single_count1 got %0d exp 1", count); end
    step(0, 0, 8'h00, 1);
    n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", rd_valid); end
    n_chk++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", rd_data); end
    n_chk++; if (count !== 11'd1) begin n_fail++; $display("FAIL single_count_hold got %0d exp 1", count); end
    step(0, 0, 8'h00, 1);
    n_chk++; if (count !== 11'd0 || rd_valid !== 1'b0 || empty !== 1'b1)
      begin n_fail++; $display("FAIL single_drain got count=%0d valid=%b empty=%b exp 0/0/1", count, rd_valid, empty); end
  endtask

  task automatic test_fill();
    int k;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i % 256), 0);
    n_chk++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 11'd1024)
      begin n_fail++; $display("FAIL fill_full got full=%b ready=%b count=%0d exp 1/0/1024", full, wr_ready, count); end
    step(0, 1, 8'hEE, 0);
    n_chk++; if (count !== 11'd1024) begin n_fail++; $display("FAIL fill_overflow_count got %0d exp 1024", count); end
    k = 0;
    for (int i = 0; i < 1100 && k < DEPTH; i++) begin
      step(0, 0, 8'h00, 1);
      if (last_rd) begin
        n_chk++;
        if (last_rd_obs !== 8'(k % 256)) begin
          n_fail++; $display("FAIL fill_drain_seq idx %0d got %h exp %h", k, last_rd_obs, 8'(k % 256));
        end
        k++;
      end
    end
    n_chk++; if (k != DEPTH) begin n_fail++; $display("FAIL fill_drain_total got %0d exp %0d", k, DEPTH); end
    step(0, 0, 8'h00, 1);
    n_chk++; if (empty !== 1'b1 || rd_valid !== 1'b0)
      begin n_fail++; $display("FAIL fill_after_drain got empty=%b valid=%b exp 1/0", empty, rd_valid); end
  endtask

  task automatic test_stall();
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h10, 0);
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h12, 0);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 0);
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== 8'h10)
        begin n_fail++; $display("FAIL stall_hold cyc %0d got valid=%b data=%h exp 1/10", i, rd_valid, rd_data); end
    end
    step(0, 0, 8'h00, 1);
    n_chk++; if (rd_valid !== 1'b1 || rd_data !== 8'h11)
      begin n_fail++; $display("FAIL stall_release got valid=%b data=%h exp 1/11", rd_valid, rd_data); end
  endtask

  task automatic test_simul();
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h31, 0);
    step(0, 1, 8'h32, 0);
    step(0, 1, 8'h33, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h34, 1);
    n_chk++; if (count !== 11'd3) begin n_fail++; $display("FAIL simul_count3 got %0d exp 3", count); end
    n_chk++; if (last_rd_obs !== 8'h31) begin n_fail++; $display("FAIL simul_rd3 got %h exp 31", last_rd_obs); end
    for (int i = 0; i < 1100 && q_data.size() < DEPTH; i++) step(0, 1, 8'($urandom), 0);
    n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_full got %b exp 1", full); end
    step(0, 1, 8'h55, 1);
    n_chk++; if (count !== 11'd1023 || full !== 1'b0)
      begin n_fail++; $display("FAIL simul_full_rw got count=%0d full=%b exp 1023/0", count, full); end
    n_chk++; if (last_rd_obs !== 8'h32) begin n_fail++; $display("FAIL simul_full_rd got %h exp 32", last_rd_obs); end
  endtask

  task automatic test_random();
    int writes, reads, iter;
    logic bad;
    step(1, 0, 8'h00, 0);
    writes = 0; reads = 0; bad = 1'b0;
    for (iter = 0; iter < 20000 && reads < 1500 && !bad; iter++) begin
      step(0, (writes < 1500) && ($urandom_range(0, 99) < 55), 8'($urandom), $urandom_range(0, 99) < 50);
      if (last_wr) writes++;
      if (last_rd) begin
        reads++;
        n_chk++; if (last_rd_obs !== last_rd_exp)
          begin n_fail++; bad = 1'b1; $display("FAIL rand_data read %0d got %h exp %h", reads, last_rd_obs, last_rd_exp); end
      end
      n_chk++; if (count !== 11'(q_data.size()) || rd_valid !== exp_valid() ||
                   full !== (q_data.size() == DEPTH) || empty !== (q_data.size() == 0) ||
                   wr_ready !== (q_data.size() != DEPTH)) begin
        n_fail++; bad = 1'b1;
        $display("FAIL rand_state cyc %0d got count=%0d valid=%b full=%b empty=%b exp count=%0d valid=%b",
                 cyc, count, rd_valid, full, empty, q_data.size(), exp_valid());
      end
      if (!bad && exp_valid()) begin
        n_chk++; if (rd_data !== q_data[0])
          begin n_fail++; bad = 1'b1; $display("FAIL rand_head got %h exp %h", rd_data, q_data[0]); end
      end
    end
    n_chk++; if (reads != 1500 || writes != 1500)
      begin n_fail++; $display("FAIL rand_totals got reads=%0d writes=%0d exp 1500/1500", reads, writes); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h60 + i), 0);
    step(0, 0, 8'h00, 0);
    n_chk++; if (count !== 11'd7 || rd_valid !== 1'b1)
      begin n_fail++; $display("FAIL rmid_pre got count=%0d valid=%b exp 7/1", count, rd_valid); end
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
    #1;
    n_chk++; if (ram_we1 !== 1'b0) begin n_fail++; $display("FAIL rmid_we1_in_rst got %b exp 0", ram_we1); end
    step(1, 1, 8'h99, 0);
    n_chk++; if (count !== 11'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || ram_we1 !== 1'b0)
      begin n_fail++; $display("FAIL rmid_post got count=%0d empty=%b valid=%b we1=%b exp 0/1/0/0",
                               count, empty, rd_valid, ram_we1); end
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    n_chk++; if (rd_valid !== 1'b0 || count !== 11'd0)
      begin n_fail++; $display("FAIL rmid_discard got valid=%b count=%0d exp 0/0", rd_valid, count); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    cyc = 0; n_chk = 0; n_fail = 0;
    last_rd = 1'b0; last_wr = 1'b0; last_rd_obs = 8'h00; last_rd_exp = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_simul();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
